// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with bypass, zero register and soft clear
//
// Purpose:
//   DEPTH x DATA_W register file (DEPTH = 2**ADDR_W) with one synchronous write
//   port, two combinational read ports, optional write-to-read bypass, optional
//   hardwired zero register and a sequenced soft-clear engine.
//
// Ports:
//   clk       in   1       clock, rising edge
//   reset     in   1       synchronous, active-high
//   wr_en     in   1       write request
//   wr_addr   in   ADDR_W  write register index
//   wr_data   in   DATA_W  write data
//   rd1_addr  in   ADDR_W  read port 1 index
//   rd1_data  out  DATA_W  read port 1 data (combinational)
//   rd2_addr  in   ADDR_W  read port 2 index
//   rd2_data  out  DATA_W  read port 2 data (combinational)
//   clr_req   in   1       soft-clear request, sampled only in IDLE
//   busy      out  1       high while the soft clear is sweeping the array
//   wr_drop   out  1       one-cycle pulse: a write was discarded because busy
module reg_file_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd2_data,
   input  logic              clr_req,
   output logic              busy,
   output logic              wr_drop
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] clr_idx_next;
   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok;

   // busy comes straight from the state flop, so it is a registered output.
   assign busy = (state == CLEAR);

   // Writes land only in IDLE; writes to a hardwired zero register vanish silently.
   assign wr_ok = wr_en && !busy && !((ZERO_REG != 0) && (wr_addr == '0));

   always_comb begin
      state_next   = state;
      clr_idx_next = clr_idx;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_next   = CLEAR;
               clr_idx_next = '0;
            end
         end
         CLEAR: begin
            // clr_req is deliberately ignored here: no restart, no extension.
            if (clr_idx == LAST_IDX) begin
               state_next   = IDLE;
               clr_idx_next = '0;
            end else begin
               clr_idx_next = clr_idx + IDX_ONE;
            end
         end
         default: begin
            state_next   = IDLE;
            clr_idx_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         state   <= IDLE;
         clr_idx <= '0;
         wr_drop <= 1'b0;
      end else begin
         state   <= state_next;
         clr_idx <= clr_idx_next;
         wr_drop <= wr_en && busy;
         // wr_ok and busy are mutually exclusive, so at most one array write per edge.
         if (wr_ok) begin
            regs[wr_addr] <= wr_data;
         end
         if (busy) begin
            regs[clr_idx] <= '0;
         end
      end
   end

   // Zero register wins over bypass; dropped writes (busy) are never forwarded.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      if ((ZERO_REG != 0) && (addr == '0)) begin
         return '0;
      end else if ((BYPASS != 0) && wr_en && !busy && (wr_addr == addr)) begin
         return wr_data;
      end else begin
         return regs[addr];
      end
   endfunction

   always_comb rd1_data = read_port(rd1_addr);
   always_comb rd2_data = read_port(rd2_addr);

endmodule
